// File: rtl/line_follow_controller.sv
// line_follow_controller
//   Upstream stage of the per-wheel motor PWM controllers in the line follower.
//   Owns the servo timebase (count_out) shared by both wheel controllers. It
//   samples the three line sensors once per timebase period and runs the
//   steering state machine that drives per-wheel direction and motor reset.
//
// Parameters:
//   PERIOD     timebase length in clk cycles; count_out runs 0..PERIOD-1
//   CW         width of count_out; must hold PERIOD-1
//   LOST_LIMIT consecutive all-white periods tolerated before stopping (1..15)
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   sensor_l    left line sensor, asynchronous, 1 = black line
//   sensor_m    middle line sensor, asynchronous, 1 = black line
//   sensor_r    right line sensor, asynchronous, 1 = black line
//   count_out   timebase count, shared with both wheel controllers
//   dir_l       left wheel direction, 1 = cw
//   dir_r       right wheel direction, 1 = cw
//   motor_rst_l left wheel controller reset, 1 = wheel off
//   motor_rst_r right wheel controller reset, 1 = wheel off
//   state_dbg   current steering state encoding (LEDs)
module line_follow_controller #(
  parameter int unsigned PERIOD     = 2000000,
  parameter int unsigned CW         = 21,
  parameter int unsigned LOST_LIMIT = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sensor_l,
  input  logic          sensor_m,
  input  logic          sensor_r,
  output logic [CW-1:0] count_out,
  output logic          dir_l,
  output logic          dir_r,
  output logic          motor_rst_l,
  output logic          motor_rst_r,
  output logic [2:0]    state_dbg
);

  typedef enum logic [2:0] {
    ST_FWD    = 3'd0,
    ST_SOFT_L = 3'd1,
    ST_HARD_L = 3'd2,
    ST_SOFT_R = 3'd3,
    ST_HARD_R = 3'd4,
    ST_STOP   = 3'd5
  } state_t;

  // Motor output bundle: {dir_l, dir_r, motor_rst_l, motor_rst_r}
  localparam logic [3:0] OUT_STOP = 4'b0011;

  // Two-flop synchronizers, bit order {l, m, r}
  logic [2:0]    sync1_q;
  logic [2:0]    sync2_q;

  logic [CW-1:0] count_q, count_d;
  logic          decision;

  state_t        state_q, state_d;
  logic [3:0]    lost_q, lost_d;
  logic [3:0]    outs_q, outs_d;
  logic          state_legal;

  // Wheel output decode. A wheel held in reset always reports direction 0.
  function automatic logic [3:0] decode(input state_t s);
    logic [3:0] o;
    case (s)
      ST_FWD:    o = 4'b1000;
      ST_SOFT_L: o = 4'b0010;
      ST_HARD_L: o = 4'b0000;
      ST_SOFT_R: o = 4'b1001;
      ST_HARD_R: o = 4'b1100;
      default:   o = OUT_STOP;
    endcase
    return o;
  endfunction

  // Sensor synchronizers
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {sensor_l, sensor_m, sensor_r};
      sync2_q <= sync1_q;
    end
  end

  // Timebase: single wrap point at PERIOD-1, which is also the decision cycle
  assign decision = (count_q == CW'(PERIOD - 1));

  always_comb begin
    count_d = count_q + 1'b1;
    if (decision) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign state_legal = (3'(state_q) <= 3'(ST_STOP));

  // Steering next-state: evaluated only in the decision cycle
  always_comb begin
    state_d = state_q;
    lost_d  = lost_q;
    if (decision) begin
      if (sync2_q == 3'b000) begin
        lost_d = (lost_q == 4'd15) ? lost_q : lost_q + 4'd1;
        // An illegal state held across a lost sample behaves as STOP
        if ((lost_d >= 4'(LOST_LIMIT)) || !state_legal) begin
          state_d = ST_STOP;
        end
      end else begin
        lost_d = '0;
        case (sync2_q)
          3'b110:  state_d = ST_SOFT_L;
          3'b100:  state_d = ST_HARD_L;
          3'b011:  state_d = ST_SOFT_R;
          3'b001:  state_d = ST_HARD_R;
          default: state_d = ST_FWD;      // 010, 111, 101
        endcase
      end
    end
  end

  // Outputs are loaded from the next state at the wrap edge so they change
  // together with the state and never mid-period; an illegal state forces
  // the STOP decode straight away.
  always_comb begin
    outs_d = outs_q;
    if (decision) begin
      outs_d = decode(state_d);
    end else if (!state_legal) begin
      outs_d = OUT_STOP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_STOP;
      lost_q  <= '0;
      outs_q  <= OUT_STOP;
    end else begin
      state_q <= state_d;
      lost_q  <= lost_d;
      outs_q  <= outs_d;
    end
  end

  assign count_out   = count_q;
  assign dir_l       = outs_q[3];
  assign dir_r       = outs_q[2];
  assign motor_rst_l = outs_q[1];
  assign motor_rst_r = outs_q[0];
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_line_follow_controller.sv
// Testbench for line_follow_controller (PERIOD=100, LOST_LIMIT=3).
// A cycle-level reference model checks every output after every clock edge;
// directed sequences and a vector table check the steering cases explicitly.
module tb_line_follow_controller;

  localparam int P  = 100;
  localparam int W  = 7;
  localparam int LL = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         sensor_l = 1'b0;
  logic         sensor_m = 1'b1;
  logic         sensor_r = 1'b0;
  logic [W-1:0] count_out;
  logic         dir_l, dir_r, motor_rst_l, motor_rst_r;
  logic [2:0]   state_dbg;

  line_follow_controller #(
    .PERIOD     (P),
    .CW         (W),
    .LOST_LIMIT (LL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sensor_l    (sensor_l),
    .sensor_m    (sensor_m),
    .sensor_r    (sensor_r),
    .count_out   (count_out),
    .dir_l       (dir_l),
    .dir_r       (dir_r),
    .motor_rst_l (motor_rst_l),
    .motor_rst_r (motor_rst_r),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model state
  int         m_count = 0;
  int         m_state = 5;
  int         m_lost  = 0;
  logic [2:0] h_prev1 = '0;   // sensors seen at the previous edge
  logic [2:0] h_prev2 = '0;   // sensors seen two edges ago

  // Steering target per {l,m,r}; -1 means line lost
  int map_tbl [8] = '{-1, 4, 0, 3, 2, 0, 1, 0};

  // Expected {dir_l, dir_r, rst_l, rst_r} per state
  function automatic logic [3:0] exp_out(input int st);
    case (st)
      0:       return 4'b1000;
      1:       return 4'b0010;
      2:       return 4'b0000;
      3:       return 4'b1001;
      4:       return 4'b1100;
      default: return 4'b0011;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic set_sens(input logic [2:0] s);
    {sensor_l, sensor_m, sensor_r} = s;
  endtask

  // One clock: advance the model on the edge, compare all outputs 1 ns later
  task automatic step();
    logic [2:0] in;
    @(posedge clk);
    in = {sensor_l, sensor_m, sensor_r};
    if (reset) begin
      m_count = 0; m_state = 5; m_lost = 0; h_prev1 = '0; h_prev2 = '0;
    end else begin
      if (m_count == P - 1) begin
        m_count = 0;
        if (h_prev2 == 3'b000) begin
          if (m_lost < 15) m_lost++;
          if (m_lost >= LL) m_state = 5;
        end else begin
          m_lost  = 0;
          m_state = map_tbl[h_prev2];
        end
      end else begin
        m_count++;
      end
      h_prev2 = h_prev1;
      h_prev1 = in;
    end
    #1;
    check("cycle", {18'b0, count_out, state_dbg, dir_l, dir_r, motor_rst_l, motor_rst_r},
          {18'b0, W'(m_count), 3'(m_state), exp_out(m_state)});
  endtask

  task automatic step_until(input int c);
    int n = 0;
    while (m_count != c && n < 2 * P) begin step(); n++; end
    if (m_count != c) check("wait_count", 32'(m_count), 32'(c));
  endtask

  task automatic run_to_wrap();
    step();
    step_until(0);
  endtask

  task automatic check_state(input string name, input int st);
    check(name, {25'b0, state_dbg, dir_l, dir_r, motor_rst_l, motor_rst_r},
          {25'b0, 3'(st), exp_out(st)});
  endtask

  typedef struct {
    logic [2:0] sens;
    int         st;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{3'b010, 0};
    vecs[1] = '{3'b110, 1};
    vecs[2] = '{3'b100, 2};
    vecs[3] = '{3'b011, 3};
    vecs[4] = '{3'b001, 4};
    vecs[5] = '{3'b111, 0};
    vecs[6] = '{3'b101, 0};

    // Reset for 3 cycles with sensors on the line
    set_sens(3'b010);
    repeat (3) step();
    check("reset_count", 32'(count_out), 32'd0);
    check_state("reset_state", 5);
    reset = 1'b0;

    // Outputs hold reset values until the first wrap
    step_until(P - 1);
    check("pre_wrap_count", 32'(count_out), 32'(P - 1));
    check_state("pre_wrap_state", 5);
    step();
    check("first_wrap_count", 32'(count_out), 32'd0);
    check("first_wrap_out", {25'b0, state_dbg, dir_l, dir_r, motor_rst_l, motor_rst_r},
          {25'b0, 3'd0, 4'b1000});

    // Mid-period sensor change takes effect only at the next wrap
    step_until(40);
    set_sens(3'b110);
    step_until(P - 1);
    check_state("soft_l_held", 0);
    step();
    check("soft_l_out", {28'b0, state_dbg, motor_rst_l}, {28'b0, 3'd1, 1'b1});
    check("soft_l_dir_r", 32'(dir_r), 32'd0);

    set_sens(3'b100); run_to_wrap(); check_state("hard_l", 2);
    set_sens(3'b001); run_to_wrap();
    check("hard_r", {29'b0, state_dbg}, 32'd4);
    check("hard_r_dirs", {30'b0, dir_l, dir_r}, 32'b11);

    // Line lost: held for LL-1 decisions, STOP on the LL-th
    set_sens(3'b010); run_to_wrap(); check_state("fwd", 0);
    set_sens(3'b000);
    run_to_wrap(); check_state("lost1", 0);
    run_to_wrap(); check_state("lost2", 0);
    run_to_wrap(); check_state("lost3_stop", 5);
    run_to_wrap(); check_state("stop_persist", 5);
    set_sens(3'b011); run_to_wrap(); check_state("recover_soft_r", 3);
    set_sens(3'b000);
    run_to_wrap(); check_state("relost1", 3);
    run_to_wrap(); check_state("relost2", 3);
    run_to_wrap(); check_state("relost3_stop", 5);

    // One-cycle glitch away from the decision cycle is ignored
    set_sens(3'b010); run_to_wrap(); check_state("glitch_pre", 0);
    step_until(50);
    set_sens(3'b011);
    step();
    set_sens(3'b010);
    run_to_wrap(); check_state("glitch_ignored", 0);

    // Reset mid-period
    step_until(60);
    reset = 1'b1;
    step();
    check("midrst_count", 32'(count_out), 32'd0);
    check_state("midrst_state", 5);
    reset = 1'b0;

    // Vector table
    foreach (vecs[i]) begin
      set_sens(vecs[i].sens);
      run_to_wrap();
      check_state("vec", vecs[i].st);
    end

    // Randomized: sensor changes at arbitrary points including near the
    // decision cycle, short glitches and occasional resets
    for (int p = 0; p < 150; p++) begin
      for (int c = 0; c < P; c++) begin
        if ($urandom_range(0, 39) == 0) begin
          if ($urandom_range(0, 2) == 0) set_sens(3'b000);
          else set_sens(3'($urandom_range(0, 7)));
        end
        if ($urandom_range(0, 1999) == 0) reset = 1'b1;
        step();
        reset = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/line_follow_controller.md
Name: line_follow_controller

Overview:
- Upstream stage of the per-wheel motor PWM controllers in the line follower.
- Owns the 20 ms servo timebase (count_out, shared by both wheel controllers). Samples the three line sensors once per period and runs a steering state machine.
- Drives per-wheel direction and per-wheel motor reset. A held motor reset parks that wheel in its off state (no pulses).

Parameters:
- PERIOD, 2000000, timebase length in clk cycles (20 ms at 100 MHz); count_out runs 0..PERIOD-1.
- CW, 21, width of count_out; must hold PERIOD-1.
- LOST_LIMIT, 5, consecutive all-white periods tolerated before stopping; range 1..15.

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  synchronous, active-high.
- sensor_l  input  1  left line sensor, asynchronous, 1 = black line.
- sensor_m  input  1  middle line sensor, asynchronous, 1 = black line.
- sensor_r  input  1  right line sensor, asynchronous, 1 = black line.
- count_out  output  CW  timebase count, shared to both wheel controllers.
- dir_l  output  1  left wheel direction, 1 = cw.
- dir_r  output  1  right wheel direction, 1 = cw.
- motor_rst_l  output  1  left wheel controller reset, 1 = wheel off.
- motor_rst_r  output  1  right wheel controller reset, 1 = wheel off.
- state_dbg  output  3  current steering state encoding, for LEDs.

Behaviour:
- Reset is synchronous and active-high on clk.

Reset values:
- count_out=0, state=STOP, motor_rst_l=motor_rst_r=1, dir_l=dir_r=0, lost_cnt=0.
- Synchronizer flops cleared to 0.
- Reset asserted mid-period: all of the above take effect on the next edge. The counter restarts from 0.

Synchronizer:
- Two-flop synchronizer per sensor. Only the synchronized values are used.

Timebase:
- count_out increments by 1 each cycle.
- At PERIOD-1 it wraps to 0; there is no other wrap point.
- The cycle with count_out==PERIOD-1 is the decision cycle.

Decision:
- In the decision cycle, synchronized {l,m,r} is sampled and next state computed.
- State and all motor outputs update on the same edge where count_out wraps to 0. Outputs never change mid-period, so pulses are never truncated.
- Mapping {l,m,r} to state:
  - 010, 111, 101 -> FWD
  - 110 -> SOFT_L
  - 100 -> HARD_L
  - 011 -> SOFT_R
  - 001 -> HARD_R
- 000 (line lost): lost_cnt increments, saturating at 15, and the state is held.
  - When lost_cnt reaches LOST_LIMIT, the state becomes STOP on that decision.
  - STOP persists until a non-000 sample.
- Any non-000 sample clears lost_cnt to 0.

Output decode (wheels mounted mirrored: forward = left cw, right ccw):
- FWD (0): dir_l=1, dir_r=0, both resets 0.
- SOFT_L (1): motor_rst_l=1, motor_rst_r=0, dir_r=0.
- HARD_L (2): dir_l=0, dir_r=0, both resets 0. Left wheel reverses.
- SOFT_R (3): motor_rst_r=1, motor_rst_l=0, dir_l=1.
- HARD_R (4): dir_l=1, dir_r=1, both resets 0. Right wheel reverses.
- STOP (5): both resets 1, dir_l=dir_r=0.
- In any state, the direction bit of a held-in-reset wheel is 0.
- Encodings 6 and 7 are illegal. If reached, the next decision maps as from STOP, and outputs decode as STOP immediately.
- state_dbg equals the state encoding above.
- All outputs are registered; there is no combinational path from sensor inputs to outputs.

Test Plan (bench uses PERIOD=100, LOST_LIMIT=3):
- Reset held 3 cycles, then released, sensors=010:
  - First wrap (cycle 100 after release): count_out goes 99->0, state_dbg goes 5->0, motor_rst_l/r go 1->0, dir_l=1, dir_r=0.
  - Before that edge, outputs stay at reset values.
- Sensors toggled 010->110 at count_out=40: outputs are unchanged until the next 99->0 wrap, then state_dbg=1, motor_rst_l=1, dir_r=0.
- Sensors=100 across a decision: state_dbg=2, dir_l=0, dir_r=0, both resets 0.
- Sensors=001 across a decision: state_dbg=4, dir_l=1, dir_r=1.
- From FWD, sensors=000:
  - The state stays 0 for wraps 1 and 2.
  - At wrap 3, state_dbg=5 and both resets are 1.
  - Sensors=011 then gives state_dbg=3 at the next wrap, with lost_cnt cleared. Verify by a second 000 streak needing 3 periods again.
- Glitch and mid-period reset:
  - A 1-cycle pulse on sensor_r at count_out=50 is ignored: state unchanged.
  - Reset asserted at count_out=60 gives count_out=0 and all reset values on the next edge.
